// File: rtl/median_window_gen.sv
// median_window_gen
// Streaming 3x3 neighbourhood generator for the median pixel network.
// Two circular line buffers hold rows y-2 (lb_old) and y-1 (lb_new). Each
// accepted raster pixel shifts a 3x3 register window by one column.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   pix_in, pix_valid    raster pixel stream (no backpressure)
//   frame_start          with pix_valid: pix_in is pixel (0,0) of a new frame
//   c1h..c3l             window taps; c1 newest column, h/m/l = rows y-2/y-1/y
//   win_valid            one-cycle pulse: taps hold a complete neighbourhood
//   win_last             with win_valid: window ends at the last column
module median_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int COL_BITS   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] pix_in,
    input  logic                  pix_valid,
    input  logic                  frame_start,
    output logic [DATA_WIDTH-1:0] c1h,
    output logic [DATA_WIDTH-1:0] c1m,
    output logic [DATA_WIDTH-1:0] c1l,
    output logic [DATA_WIDTH-1:0] c2h,
    output logic [DATA_WIDTH-1:0] c2m,
    output logic [DATA_WIDTH-1:0] c2l,
    output logic [DATA_WIDTH-1:0] c3h,
    output logic [DATA_WIDTH-1:0] c3m,
    output logic [DATA_WIDTH-1:0] c3l,
    output logic                  win_valid,
    output logic                  win_last
);

    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [COL_BITS-1:0] MIN_COL  = COL_BITS'(2);

    logic [COL_BITS-1:0]   col, eff_col, col_nxt;
    logic [1:0]            row, eff_row, row_nxt;
    logic [AW-1:0]         idx;
    logic                  at_last;
    logic [DATA_WIDTH-1:0] rd_h, rd_m;

    // Line buffers: contents are never reset; stale data is masked by the
    // row/col gating of win_valid.
    logic [DATA_WIDTH-1:0] lb_old [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb_new [IMG_WIDTH];

    // frame_start overrides the counters for the pixel that carries it, so
    // the new frame's first pixel lands at (0,0) in the same edge.
    always_comb begin
        eff_col = frame_start ? '0 : col;
        eff_row = frame_start ? '0 : row;
        idx     = eff_col[AW-1:0];
        rd_h    = lb_old[idx];
        rd_m    = lb_new[idx];
        at_last = (eff_col == LAST_COL);
        col_nxt = at_last ? '0 : eff_col + 1'b1;
        row_nxt = eff_row;
        if (at_last && eff_row != 2'd2)
            row_nxt = eff_row + 2'd1;
    end

    // Read-before-write at one index: rd_h/rd_m above see pre-edge values.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb_old[idx] <= lb_new[idx];
            lb_new[idx] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            c1h       <= '0;
            c1m       <= '0;
            c1l       <= '0;
            c2h       <= '0;
            c2m       <= '0;
            c2l       <= '0;
            c3h       <= '0;
            c3m       <= '0;
            c3l       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (pix_valid) begin
            col       <= col_nxt;
            row       <= row_nxt;
            c3h       <= c2h;
            c3m       <= c2m;
            c3l       <= c2l;
            c2h       <= c1h;
            c2m       <= c1m;
            c2l       <= c1l;
            c1h       <= rd_h;
            c1m       <= rd_m;
            c1l       <= pix_in;
            // First two columns still carry previous-line data in c2/c3.
            win_valid <= (eff_row == 2'd2) && (eff_col >= MIN_COL);
            win_last  <= at_last;
        end else begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_median_window_gen.sv
// tb_median_window_gen
// Drives two instances (IMG_WIDTH 4 and 8) from one shared pixel stream and
// checks every cycle against a frame-image reference model: accepted pixels
// are kept per frame in raster order, and the expected window is read
// straight out of that image by (row, col).
module tb_median_window_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       frame_start;

    logic [7:0] a1h, a1m, a1l, a2h, a2m, a2l, a3h, a3m, a3l;
    logic [7:0] b1h, b1m, b1l, b2h, b2m, b2l, b3h, b3m, b3l;
    logic       a_v, a_l, b_v, b_l;

    always #5 clk = ~clk;

    median_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(4), .COL_BITS(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
        .frame_start(frame_start),
        .c1h(a1h), .c1m(a1m), .c1l(a1l), .c2h(a2h), .c2m(a2m), .c2l(a2l),
        .c3h(a3h), .c3m(a3m), .c3l(a3l), .win_valid(a_v), .win_last(a_l));

    median_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(8), .COL_BITS(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
        .frame_start(frame_start),
        .c1h(b1h), .c1m(b1m), .c1l(b1l), .c2h(b2h), .c2m(b2m), .c2l(b2l),
        .c3h(b3h), .c3m(b3m), .c3l(b3l), .win_valid(b_v), .win_last(b_l));

    logic [7:0] obs [2][9];
    logic       obs_v [2];
    logic       obs_l [2];
    assign obs[0] = '{a1h, a1m, a1l, a2h, a2m, a2l, a3h, a3m, a3l};
    assign obs[1] = '{b1h, b1m, b1l, b2h, b2m, b2l, b3h, b3m, b3l};
    assign obs_v[0] = a_v;
    assign obs_v[1] = b_v;
    assign obs_l[0] = a_l;
    assign obs_l[1] = b_l;

    // ---------------- reference model ----------------
    int         errors = 0;
    int         checks = 0;
    int         wid [2] = '{4, 8};
    logic [7:0] img0 [$];
    logic [7:0] img1 [$];
    logic [7:0] expw [2][9];
    bit         have_win [2];
    bit         exp_v [2];
    bit         exp_l [2];
    int         exp_r [2];
    int         pulses [2];

    task automatic chk(input string tag, input int d, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, wid[d], o, e);
        end
    endtask

    function automatic logic [7:0] pix_at(input int d, input int i);
        return (d == 0) ? img0[i] : img1[i];
    endfunction

    function automatic logic [7:0] median9(input logic [7:0] a [9]);
        logic [7:0] s [9];
        logic [7:0] t;
        s = a;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        return s[4];
    endfunction

    task automatic model_reset();
        img0.delete();
        img1.delete();
        for (int d = 0; d < 2; d++) begin
            have_win[d] = 0;
            pulses[d]   = 0;
        end
    endtask

    task automatic model_accept(input int d, input logic fs, input logic [7:0] px);
        int n, k, r, c, w;
        w = wid[d];
        if (fs) begin
            if (d == 0) img0.delete(); else img1.delete();
            pulses[d] = 0;
        end
        if (d == 0) begin img0.push_back(px); n = img0.size(); end
        else        begin img1.push_back(px); n = img1.size(); end
        k = n - 1;
        r = k / w;
        c = k % w;
        exp_r[d] = r;
        exp_v[d] = (r >= 2) && (c >= 2);
        exp_l[d] = (c == w - 1);
        if (exp_v[d])
            for (int j = 0; j < 3; j++)       // column c-j
                for (int i = 0; i < 3; i++)   // row r-2+i (h, m, l)
                    expw[d][j*3+i] = pix_at(d, (r - 2 + i) * w + (c - j));
        have_win[d] = exp_v[d];
    endtask

    task automatic check_dut(input int d, input logic pv);
        chk("win_valid", d, 32'(obs_v[d]), pv ? 32'(exp_v[d]) : 32'd0);
        chk("win_last",  d, 32'(obs_l[d]), pv ? 32'(exp_l[d]) : 32'd0);
        if (have_win[d])
            for (int t = 0; t < 9; t++)
                chk(pv ? "tap" : "tap_hold", d, 32'(obs[d][t]), 32'(expw[d][t]));
        if (pv && exp_v[d])
            chk("median", d, 32'(median9(obs[d])), 32'(median9(expw[d])));
        if (obs_v[d] === 1'b1) pulses[d]++;
        if (pv && exp_l[d]) begin
            if (exp_r[d] >= 2)
                chk("pulses_per_line", d, 32'(pulses[d]), 32'(wid[d] - 2));
            pulses[d] = 0;
        end
    endtask

    task automatic check_reset_state();
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", d, 32'(obs_v[d]), 32'd0);
            chk("rst_last",  d, 32'(obs_l[d]), 32'd0);
            for (int t = 0; t < 9; t++)
                chk("rst_tap", d, 32'(obs[d][t]), 32'd0);
        end
    endtask

    task automatic step(input logic pv, input logic fs, input logic [7:0] px);
        pix_valid   = pv;
        frame_start = fs;
        pix_in      = px;
        @(posedge clk);
        #1;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        if (pv) begin
            model_accept(0, fs, px);
            model_accept(1, fs, px);
        end
        check_dut(0, pv);
        check_dut(1, pv);
    endtask

    task automatic maybe_gap(input int max_gap);
        if ($urandom_range(0, 1) == 1) begin
            int g;
            g = $urandom_range(1, max_gap);
            for (int i = 0; i < g; i++) step(1'b0, 1'b0, 8'($urandom));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b0;
        pix_in      = '0;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        model_reset();
        #1;
        check_reset_state();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous frame, pixel value 16*r+c.
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 4; c++)
                step(1'b1, (r == 0 && c == 0), 8'(16 * r + c));

        // Same frame with random idle gaps.
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 4; c++) begin
                maybe_gap(5);
                step(1'b1, (r == 0 && c == 0), 8'(16 * r + c));
            end

        // Abandon a frame at (2,1) with a new frame_start.
        for (int k = 0; k < 9; k++)
            step(1'b1, (k == 0), 8'(16 * (k / 4) + (k % 4)));
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                step(1'b1, (r == 0 && c == 0), 8'(8'hA0 + 16 * r + c));

        // Asynchronous reset mid-frame, taps clear without a clock edge.
        for (int k = 0; k < 6; k++)
            step(1'b1, (k == 0), 8'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_state();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 2 * 4 + 3 + 5; k++) begin
            maybe_gap(3);
            step(1'b1, 1'b0, 8'($urandom));
        end

        // Random data frame: exercises the 8-wide instance and median check.
        for (int k = 0; k < 48; k++) begin
            maybe_gap(4);
            step(1'b1, (k == 0), 8'($urandom));
        end
        step(1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end of stimulus");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/median_window_gen.md
# median_window_gen

Streaming 3x3 window generator feeding the median pixel network. It accepts one raster-scan pixel per qualified clock and keeps the two previous image lines in circular line buffers. It shifts a 3x3 register window and presents the nine window taps (c1..c3 by h/m/l) with a registered valid flag, so the combinational median network downstream sees a complete neighbourhood every valid cycle.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width in bits
- IMG_WIDTH, 640, pixels per line, minimum 3
- COL_BITS, 10, column counter width, must satisfy 2^COL_BITS >= IMG_WIDTH

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pix_in  in  DATA_WIDTH  incoming pixel, raster order
- pix_valid  in  1  pix_in is accepted on this edge; no backpressure
- frame_start  in  1  qualified by pix_valid; marks pix_in as pixel (row 0, col 0) of a new frame
- c1h, c1m, c1l  out  DATA_WIDTH  newest window column, rows y-2 / y-1 / y
- c2h, c2m, c2l  out  DATA_WIDTH  middle window column
- c3h, c3m, c3l  out  DATA_WIDTH  oldest window column
- win_valid  out  1  window taps hold a complete 3x3 neighbourhood, one-cycle pulse per accepted pixel
- win_last  out  1  with win_valid: window ends at the last column of the line

## Operation
- State: col counter (0..IMG_WIDTH-1), row counter (saturating 0..2), line buffers lb_old and lb_new (IMG_WIDTH x DATA_WIDTH each), 9 window registers.
- Effective position on an accepting edge: if frame_start=1, (row,col) = (0,0); otherwise the current counters.
- On each edge with pix_valid=1, indexed at effective col:
  - read h = lb_old[col], m = lb_new[col] (values before this edge's write)
  - write lb_old[col] <= lb_new[col], lb_new[col] <= pix_in
  - shift window: c3* <= c2*, c2* <= c1*, c1h <= h, c1m <= m, c1l <= pix_in
  - win_valid <= (row == 2) && (col >= 2); win_last <= (col == IMG_WIDTH-1)
  - col <= col+1, wrapping IMG_WIDTH-1 -> 0. On wrap, row <= row+1, saturating at 2.
- On edges with pix_valid=0: window, counters and buffers hold; win_valid <= 0, win_last <= 0.
- Windows never straddle lines. The col >= 2 gate suppresses the first two pixels of each line, whose window still contains previous-line columns.
- frame_start does not clear line buffers or window registers. Stale contents are masked by the row/col gating.
- Line buffers use a read-before-write single-index access. Registers or inferred RAM with that behaviour are both acceptable. Buffer contents are not reset.

## Timing
- Reset (rst_n low, asynchronous): col=0, row=0, all nine window outputs 0, win_valid=0, win_last=0. Release is synchronous to clk.
- Latency: the pixel accepted on edge N appears on c1l after edge N, and the corresponding win_valid is high for the cycle following edge N.
- Throughput: one window per clock at continuous pix_valid. Per line of IMG_WIDTH pixels (row>=2), exactly IMG_WIDTH-2 win_valid pulses, the last with win_last=1.
- pix_valid gaps of any length are lossless. Outputs stay stable through a gap; only win_valid/win_last drop.
- frame_start mid-line or mid-frame: the in-progress frame is abandoned. No win_valid until row 2, col 2 of the new frame.
- Reset mid-frame: same as power-up. The first window appears only after 2*IMG_WIDTH+3 accepted pixels.
- Downstream median output is valid combinationally in the cycle win_valid is high.

## Test plan
- Reset: assert rst_n=0 mid-stream -> all taps 0, win_valid=0 immediately (no clock edge needed); counters 0 after release.
- IMG_WIDTH=4, continuous pixels value 16*r+c with frame_start on the first -> first win_valid after pixel 0x22: c1=0x02/0x12/0x22, c2=0x01/0x11/0x21, c3=0x00/0x10/0x20, win_last=0. Next window after pixel 0x23 has win_last=1. Exactly 2 pulses per line.
- Row 3 continuation -> window after pixel 0x32 is c1=0x12/0x22/0x32. The first two pixels of the line produce no win_valid.
- Same stream with random pix_valid gaps (1-5 cycles) -> identical sequence of window values on win_valid cycles; taps constant during gaps.
- frame_start asserted at row 2, col 1 -> no win_valid until new-frame pixel (2,2). That window contains only new-frame data.
- Median check: drive the 3x3 windows into the median network with random data, IMG_WIDTH=8 -> the median output matches a software 3x3 median at every win_valid.
